// File: rtl/mem_burst_arbiter.sv
// Two-port burst arbiter sharing single-port main memory between I$ (port 0) and D$ (port 1).
// Each grant runs a fixed BEATS-word block transfer; owner alternates round-robin on contention.
// Ports: clk, rst (async, active-high); req/rw per requester; addr0/addr1 block addresses;
//        wdata0/wdata1 per-beat write data; gnt/beat/done/last/rdata to the owner;
//        mem_req/mem_rw/mem_addr/mem_wdata to memory, mem_done/mem_rdata back; err watchdog flag.
// Optional: define MEM_TIMEOUT_EN to enable the per-beat watchdog (TIMEOUT_CYCLES).
module mem_burst_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int BEATS          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req,
    input  logic [1:0]                 rw,
    input  logic [ADDR_W-1:0]          addr0,
    input  logic [ADDR_W-1:0]          addr1,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic [DATA_W-1:0]          wdata1,
    output logic [1:0]                 gnt,
    output logic [$clog2(BEATS)-1:0]   beat,
    output logic [1:0]                 done,
    output logic                       last,
    output logic [DATA_W-1:0]          rdata,
    output logic                       mem_req,
    output logic                       mem_rw,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_done,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       err
);

    localparam int BW = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT,
        ST_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic                rr_q, rr_d;
    logic                own_q, own_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [1:0]          done_q, done_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                pick;
    logic [ADDR_W-1:0]   pick_addr;

    // Low nibble of the block address never reaches the memory side.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[3:0], addr1[3:0]};

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Contention goes to the rr pointer; a lone requester always wins.
    assign pick      = (req == 2'b11) ? rr_q : req[1];
    assign pick_addr = pick ? addr1 : addr0;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        own_d   = own_q;
        rw_d    = rw_q;
        base_d  = base_q;
        beat_d  = beat_q;
        done_d  = 2'b00;
        last_d  = 1'b0;
        rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    own_d   = pick;
                    rw_d    = pick ? rw[1] : rw[0];
                    base_d  = {pick_addr[ADDR_W-1:4], 4'b0000};
                    beat_d  = '0;
                    state_d = ST_BEAT;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BEAT: begin
                if (mem_done) begin
                    rdata_d = mem_rdata;
                    done_d  = own_q ? 2'b10 : 2'b01;
                    last_d  = (beat_q == LAST_BEAT);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_RELEASE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                    cnt_d = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the burst silently: no done/last for this beat.
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_RELEASE: begin
                rr_d    = ~own_q;
                beat_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            own_q   <= 1'b0;
            rw_q    <= 1'b0;
            base_q  <= '0;
            beat_q  <= '0;
            done_q  <= 2'b00;
            last_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            rw_q    <= rw_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Memory-side strobes are decoded straight from state so they drop
    // immediately on async reset and in RELEASE.
    assign mem_req   = (state_q == ST_BEAT);
    assign mem_rw    = mem_req & rw_q;
    assign mem_addr  = mem_req ? (base_q | (ADDR_W'(beat_q) << 2)) : '0;
    assign mem_wdata = !mem_req ? '0 : (own_q ? wdata1 : wdata0);
    assign gnt       = !mem_req ? 2'b00 : (own_q ? 2'b10 : 2'b01);
    assign beat      = beat_q;
    assign done      = done_q;
    assign last      = last_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard testbench for mem_burst_arbiter: random memory latency, random requests,
// reference burst list built from block-address arithmetic and round-robin order.
module tb_mem_burst_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req, rw;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    gnt;
    logic [1:0]    beat;
    logic [1:0]    done;
    logic          last;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic          err;

    always #5 clk = ~clk;

    mem_burst_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .BEATS(NB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .rw(rw),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .beat(beat), .done(done), .last(last), .rdata(rdata),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .err(err)
    );

    typedef struct {
        bit            port;
        bit            rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            last;
        int            idx;
    } beat_t;

    beat_t         exp_mem[$];
    beat_t         exp_done[$];
    int            errors = 0;
    int            checks = 0;
    bit            rr_m = 1'b0;
    logic [DW-1:0] wbase[2];
    int            widx[2];
    bit            mem_en = 1'b1;

    assign wdata0 = wbase[0] + DW'(widx[0]);
    assign wdata1 = wbase[1] + DW'(widx[1]);

    task automatic check(string nm, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [83:0] outs();
        return {gnt, beat, done, last, rdata, mem_req, mem_rw,
                mem_addr, mem_wdata, err};
    endfunction

    // Reference: a granted burst is NB words starting at the 16-byte block,
    // and the pointer then favours the other port.
    task automatic push_burst(bit p, bit rwv, logic [AW-1:0] a,
                              logic [DW-1:0] rb, bit rnd);
        beat_t b;
        for (int i = 0; i < NB; i++) begin
            b.port  = p;
            b.rw    = rwv;
            b.addr  = AW'((int'(a) / 16) * 16 + 4 * i);
            b.wdata = wbase[p] + DW'(i);
            b.rdata = rnd ? DW'($urandom) : rb + DW'(i);
            b.last  = (i == NB - 1);
            b.idx   = i;
            exp_mem.push_back(b);
        end
        rr_m = ~p;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((exp_mem.size() != 0 || exp_done.size() != 0 ||
                req != 2'b00 || gnt != 2'b00) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("burst_complete", 128'(n < budget), 128'(1));
        if (n >= budget) begin
            exp_mem.delete();
            exp_done.delete();
            req = 2'b00;
        end
        repeat (2) @(negedge clk);
    endtask

    // Requesters: advance write word after each done, drop req once served.
    initial begin
        widx[0] = 0;
        widx[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                widx[0] = 0;
                widx[1] = 0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (done[p]) begin
                        widx[p] = (widx[p] + 1) % NB;
                        req[p]  = 1'b0;
                    end
                end
            end
        end
    end

    // Memory model: random latency, one-cycle done, gap cycle after each pulse.
    initial begin
        int    lat;
        beat_t m;
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && !rst) begin
                lat = $urandom_range(0, 2);
                repeat (lat) @(negedge clk);
                if (mem_req === 1'b1 && !rst && mem_en) begin
                    if (exp_mem.size() == 0) begin
                        check("unexpected_mem_access", 128'(mem_addr), 128'(0));
                    end else begin
                        m = exp_mem.pop_front();
                        check("mem_side", {beat, gnt, mem_rw, mem_addr},
                              {2'(m.idx), (m.port ? 2'b10 : 2'b01), m.rw, m.addr});
                        if (m.rw)
                            check("mem_wdata", 128'(mem_wdata), 128'(m.wdata));
                        mem_rdata = m.rdata;
                        mem_done  = 1'b1;
                        exp_done.push_back(m);
                        @(negedge clk);
                        mem_done  = 1'b0;
                        mem_rdata = DW'($urandom);
                    end
                end
            end
        end
    end

    // Monitor: every done pulse consumes one expected beat; after a final
    // beat with a pending requester, gnt must show it two cycles later.
    initial begin
        beat_t      e;
        int         rg_cnt = 0;
        logic [1:0] rg_exp = 2'b00;
        forever begin
            @(negedge clk);
            if (rg_cnt > 0) begin
                rg_cnt--;
                if (rg_cnt == 0)
                    check("regrant", 128'(gnt), 128'(rg_exp));
            end
            if (!rst && done != 2'b00) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 128'(done), 128'(0));
                end else begin
                    e = exp_done.pop_front();
                    check("done_rdata_last", {done, last, rdata},
                          {(e.port ? 2'b10 : 2'b01), e.last, e.rdata});
                end
                if (last && req != 2'b00) begin
                    rg_exp = req;
                    rg_cnt = 2;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int  n;
        bit  f;
        logic [1:0] mask;
        rst   = 1'b1;
        req   = 2'b00;
        rw    = 2'b00;
        addr0 = '0;
        addr1 = '0;
        wbase[0] = '0;
        wbase[1] = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", 128'(outs()), 128'(0));
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outs", 128'(outs()), 128'(0));
        end

        // Port 0 read of block 0x120 with known memory data.
        wbase[0] = 32'h0;
        push_burst(1'b0, 1'b0, 10'h125, 32'hA0, 1'b0);
        rw    = 2'b00;
        addr0 = 10'h125;
        req   = 2'b01;
        @(negedge clk);
        check("grant_latency", {gnt, mem_req, beat, mem_addr},
              {2'b01, 1'b1, 2'b00, 10'h120});
        wait_idle(200);

        // Port 0 write leaves rr pointing at port 1; abort it with reset.
        wbase[0] = DW'($urandom);
        push_burst(1'b0, 1'b1, AW'($urandom), '0, 1'b1);
        rw    = 2'b01;
        addr0 = exp_mem[0].addr;
        req   = 2'b01;
        n = 0;
        while (widx[0] != 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_beat3", 128'(n < 200), 128'(1));
        #3 rst = 1'b1;
        #1 check("async_reset_outs", 128'(outs()), 128'(0));
        repeat (2) @(negedge clk);
        exp_mem.delete();
        exp_done.delete();
        req  = 2'b00;
        rr_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Both request after reset: port 0 first, then port 1 writes 0x3F0.
        wbase[0] = DW'($urandom);
        wbase[1] = 32'h5000_0000;
        f = rr_m;
        push_burst(f, f ? 1'b1 : 1'b0, f ? 10'h3F0 : 10'h240, '0, 1'b1);
        push_burst(~f, ~f ? 1'b1 : 1'b0, ~f ? 10'h3F0 : 10'h240, '0, 1'b1);
        rw    = 2'b10;
        addr0 = 10'h240;
        addr1 = 10'h3F0;
        req   = 2'b11;
        wait_idle(300);

        // Port 1 alone; port 0 arrives mid-burst after port 1 drops req.
        wbase[1] = DW'($urandom);
        wbase[0] = DW'($urandom);
        addr1 = AW'($urandom);
        addr0 = AW'($urandom);
        rw    = 2'(($urandom));
        push_burst(1'b1, rw[1], addr1, '0, 1'b1);
        push_burst(1'b0, rw[0], addr0, '0, 1'b1);
        req = 2'b10;
        n = 0;
        while (req[1] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("port1_first_done", 128'(n < 200), 128'(1));
        req[0] = 1'b1;
        wait_idle(300);

        // Randomized traffic.
        for (int it = 0; it < 16; it++) begin
            mask     = 2'($urandom_range(1, 3));
            rw       = 2'($urandom);
            addr0    = AW'($urandom);
            addr1    = AW'($urandom);
            wbase[0] = DW'($urandom);
            wbase[1] = DW'($urandom);
            if (mask == 2'b11) begin
                f = rr_m;
                push_burst(f, rw[f], f ? addr1 : addr0, '0, 1'b1);
                push_burst(~f, rw[~f], ~f ? addr1 : addr0, '0, 1'b1);
            end else begin
                f = mask[1];
                push_burst(f, rw[f], f ? addr1 : addr0, '0, 1'b1);
            end
            req = mask;
            wait_idle(300);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

`ifdef MEM_TIMEOUT_EN
        mem_en = 1'b0;
        req    = 2'b01;
        @(negedge clk);
        req = 2'b00;
        repeat (TO) @(negedge clk);
        check("timeout_err", {err, gnt, done}, {1'b1, 2'b00, 2'b00});
        repeat (3) @(negedge clk);
        check("err_sticky", 128'(err), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("err_cleared", 128'(err), 128'(0));
        mem_en = 1'b1;
`else
        check("err_low", 128'(err), 128'(0));
`endif
        check("queues_empty", 128'(exp_mem.size() + exp_done.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
